// File: rtl/command_executor.sv
// Route command executor: queues planner turn commands and steps through them
// at each detected line node, driving the two wheel motors and tracking heading.
module command_executor #(
    parameter int DEPTH    = 8,
    parameter int TURN_MIN = 1000,
    parameter int TIMEOUT  = 100000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       go,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_data,
    input  logic       cmd_last,
    output logic       cmd_ready,
    input  logic       node_det,
    input  logic       line_ok,
    output logic [1:0] motor_l,
    output logic [1:0] motor_r,
    output logic [1:0] heading,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW   = AW + 1;
    localparam int CMAX = (2 * TURN_MIN > TIMEOUT) ? 2 * TURN_MIN : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FOLLOW = 3'd1;
    localparam logic [2:0] S_BLIND  = 3'd2;
    localparam logic [2:0] S_SEEK   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [1:0] CMD_STRAIGHT = 2'b00;
    localparam logic [1:0] CMD_LEFT     = 2'b01;
    localparam logic [1:0] CMD_RIGHT    = 2'b10;
    localparam logic [1:0] CMD_BACK     = 2'b11;

    localparam logic [1:0] MOT_STOP = 2'b00;
    localparam logic [1:0] MOT_FWD  = 2'b01;
    localparam logic [1:0] MOT_REV  = 2'b10;

    localparam logic [1:0] HD_W = 2'b00;
    localparam logic [1:0] HD_E = 2'b01;
    localparam logic [1:0] HD_N = 2'b10;
    localparam logic [1:0] HD_S = 2'b11;

    localparam logic [CW-1:0] BLIND_LAST  = CW'(TURN_MIN - 1);
    localparam logic [CW-1:0] BLIND2_LAST = CW'(2 * TURN_MIN - 1);
    localparam logic [CW-1:0] SEEK_LAST   = CW'(TIMEOUT - 1);

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NW-1:0] count_q, count_d;
    logic          full, empty, push, pop;
    logic [1:0]    head_cmd;
    logic          head_last;

    logic node_s1_q, node_s2_q, node_prev_q;
    logic line_s1_q, line_s2_q;
    logic node_edge;

    logic [2:0]    state_q, state_d;
    logic [1:0]    heading_q, heading_d;
    logic [1:0]    turn_q, turn_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [1:0] next_heading(input logic [1:0] h, input logic [1:0] c);
        logic [1:0] r;
        r = h;
        case (c)
            CMD_LEFT: begin
                case (h)
                    HD_W:    r = HD_S;
                    HD_S:    r = HD_E;
                    HD_E:    r = HD_N;
                    default: r = HD_W;
                endcase
            end
            CMD_RIGHT: begin
                case (h)
                    HD_W:    r = HD_N;
                    HD_N:    r = HD_E;
                    HD_E:    r = HD_S;
                    default: r = HD_W;
                endcase
            end
            CMD_BACK: r = h ^ 2'b01;
            default:  r = h;
        endcase
        return r;
    endfunction

    // cmd handshake: an entry transfers on a rising edge where cmd_valid && cmd_ready;
    // the planner holds cmd_data/cmd_last stable while cmd_valid is high and not accepted.
    assign full      = (count_q == NW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head_cmd  = mem_q[rd_ptr_q][1:0];
    assign head_last = mem_q[rd_ptr_q][2];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_last, cmd_data};
        end
    end

    assign node_edge = node_s2_q && !node_prev_q;

    always_comb begin
        state_d   = state_q;
        heading_d = heading_q;
        turn_d    = turn_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go && !empty) state_d = S_FOLLOW;
            end
            S_FOLLOW: begin
                if (node_edge) begin
                    if (empty) begin
                        state_d = S_ERROR;
                    end else begin
                        pop    = 1'b1;
                        turn_d = head_cmd;
                        last_d = head_last;
                        cnt_d  = '0;
                        if (head_cmd == CMD_STRAIGHT) state_d = head_last ? S_DONE : S_FOLLOW;
                        else                          state_d = S_BLIND;
                    end
                end
            end
            S_BLIND: begin
                // Backward turns spin for twice as long before looking for the line.
                if (cnt_q == ((turn_q == CMD_BACK) ? BLIND2_LAST : BLIND_LAST)) begin
                    state_d = S_SEEK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SEEK: begin
                if (line_s2_q) begin
                    heading_d = next_heading(heading_q, turn_q);
                    state_d   = last_q ? S_DONE : S_FOLLOW;
                end else if (cnt_q == SEEK_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (go) state_d = S_IDLE;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            node_s1_q   <= 1'b0;
            node_s2_q   <= 1'b0;
            node_prev_q <= 1'b0;
            line_s1_q   <= 1'b0;
            line_s2_q   <= 1'b0;
            state_q     <= S_IDLE;
            heading_q   <= HD_W;
            turn_q      <= CMD_STRAIGHT;
            last_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            node_s1_q   <= node_det;
            node_s2_q   <= node_s1_q;
            node_prev_q <= node_s2_q;
            line_s1_q   <= line_ok;
            line_s2_q   <= line_s1_q;
            state_q     <= state_d;
            heading_q   <= heading_d;
            turn_q      <= turn_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        motor_l = MOT_STOP;
        motor_r = MOT_STOP;
        case (state_q)
            S_FOLLOW: begin
                motor_l = MOT_FWD;
                motor_r = MOT_FWD;
            end
            S_BLIND, S_SEEK: begin
                if (turn_q == CMD_LEFT) begin
                    motor_l = MOT_REV;
                    motor_r = MOT_FWD;
                end else begin
                    motor_l = MOT_FWD;
                    motor_r = MOT_REV;
                end
            end
            default: begin
                motor_l = MOT_STOP;
                motor_r = MOT_STOP;
            end
        endcase
    end

    assign heading   = heading_q;
    assign busy      = (state_q == S_FOLLOW) || (state_q == S_BLIND) || (state_q == S_SEEK);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERROR);
    assign state_dbg = state_q;

endmodule

// File: doc/command_executor.md
COMMAND_EXECUTOR -- requirements
Module: command_executor

Interface
REQ-001 Parameter DEPTH, default 8: command FIFO entries (power of two).
REQ-002 Parameter TURN_MIN, default 1000: blind-turn cycles before line search begins.
REQ-003 Parameter TIMEOUT, default 100000: maximum TURN_SEEK cycles.
REQ-004 clk_50  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 go  in  1  start/restart request, sampled one cycle wide.
REQ-007 cmd_valid  in  1  planner command present.
REQ-008 cmd_data  in  2  command: 00 straight, 01 left, 10 right, 11 backward.
REQ-009 cmd_last  in  1  marks the final command of a route.
REQ-010 cmd_ready  out  1  FIFO can accept; equals !full.
REQ-011 node_det  in  1  asynchronous level from the node sensor.
REQ-012 line_ok  in  1  asynchronous level, centre sensor on line.
REQ-013 motor_l, motor_r  out  2 each  00 stop, 01 forward, 10 reverse.
REQ-014 heading  out  2  00 west, 01 east, 10 north, 11 south.
REQ-015 busy  out  1  high in FOLLOW, TURN_BLIND and TURN_SEEK.
REQ-016 done  out  1  high in DONE.
REQ-017 err  out  1  high in ERROR.

Function
REQ-018 FIFO: DEPTH x 3 bits {last, cmd}. Push on cmd_valid && cmd_ready. Pop only as defined in REQ-023. Simultaneous push and pop leaves the count unchanged. No push when full.
REQ-019 node_det and line_ok each pass through a 2-flop synchronizer. node_edge is a one-cycle pulse on the synchronized 0->1 transition.
REQ-020 States are IDLE, FOLLOW, TURN_BLIND, TURN_SEEK, DONE and ERROR. Motors are 00/00 in IDLE, DONE and ERROR.
REQ-021 IDLE -> FOLLOW on go=1 with FIFO non-empty. go is ignored while the FIFO is empty.
REQ-022 FOLLOW drives both motors 01.
REQ-023 node_edge in FOLLOW with FIFO non-empty pops the head entry in that same cycle. The action below appears on the outputs in the next cycle.
REQ-024 Popped straight: heading unchanged. Go to DONE if last=1, otherwise remain in FOLLOW.
REQ-025 Popped left: motor_l=10, motor_r=01. Popped right or backward: motor_l=01, motor_r=10. The state enters TURN_BLIND and the turn counter is cleared.
REQ-026 TURN_BLIND lasts TURN_MIN cycles, or 2*TURN_MIN for backward, then enters TURN_SEEK.
REQ-027 TURN_SEEK keeps the turn motors. When synchronized line_ok=1, heading updates and the state goes to DONE if last=1, otherwise to FOLLOW.
REQ-028 TURN_SEEK reaching TIMEOUT cycles without line_ok goes to ERROR.
REQ-029 node_edge in FOLLOW with FIFO empty goes to ERROR, with no pop.
REQ-030 Heading update, left: W->S, S->E, E->N, N->W.
REQ-031 Heading update, right: W->N, N->E, E->S, S->W.
REQ-032 Heading update, backward: W<->E, N<->S. Straight leaves heading unchanged.
REQ-033 node_edge in TURN_BLIND, TURN_SEEK, IDLE, DONE or ERROR is ignored, with no pop.
REQ-034 DONE -> IDLE on go=1.
REQ-035 ERROR is exited only by reset.
REQ-036 Counters are wide enough for 2*TURN_MIN and TIMEOUT without wrap.

Reset
REQ-037 rst_n=0 immediately sets: state IDLE, FIFO empty, cmd_ready=1, motors 00/00, heading=00 (west), busy=0, done=0, err=0, synchronizers 0 and counters 0.
REQ-038 Reset asserted mid-turn or mid-route discards all queued commands.
REQ-039 Release of rst_n is synchronous to clk_50.

Verification
REQ-040 Load {0,left},{0,straight},{1,right}, pulse go, give 3 node edges, and raise line_ok after each blind phase -> heading sequence W, S, S, W, then DONE with motors 00/00.
REQ-041 Push 9 commands with DEPTH=8 -> cmd_ready=0 after the 8th push, the 9th is held, and cmd_ready returns to 1 on the first pop.
REQ-042 Backward command at heading N with TURN_MIN=10 -> exactly 20 TURN_BLIND cycles, then TURN_SEEK, then heading=S on line_ok.
REQ-043 Node edge in FOLLOW with FIFO empty -> err=1 and motors 00/00 from the next cycle; go has no effect.
REQ-044 line_ok held 0 in TURN_SEEK with TIMEOUT=50 -> ERROR after 50 seek cycles.
REQ-045 rst_n low during TURN_SEEK -> all outputs take their reset values asynchronously, the FIFO is empty, and a later go is ignored.
